clk_strobe_gen: RTL and testbench



---
 rtl/clk_strobe_gen.sv | 142 ++++++++++++++
 tb/tb_clk_strobe_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_strobe_gen.sv
// Clock-enable generator for the 8080-class cores: CPU phase, timer/DMA, pixel and aux strobes.
// Optional CPU pause is built only when CLK_STROBE_GEN_PAUSE_EN is defined.
module clk_strobe_gen #(
    parameter int FRAME_LEN = 28,
    parameter int F2_OFS    = 2,
    parameter int PIT_OFS   = 4,
    parameter int PIX_DIV   = 6,
    parameter int AUX_W     = 12,
    parameter int AUX_DIV   = 3571
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [1:0] speed,
    input  logic       pause,
    output logic       ce_f1,
    output logic       ce_f2,
    output logic       ce_pit,
    output logic       ce_dma,
    output logic       ce_pix,
    output logic       ce_pix2x,
    output logic       ce_aux,
    output logic [1:0] speed_act,
    output logic       paused
);

    localparam int FRAME_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam int PIX_W   = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;

    localparam logic [FRAME_W-1:0] FRAME_LAST   = FRAME_W'(FRAME_LEN - 1);
    localparam logic [FRAME_W-1:0] SLOT_LAST_2X = FRAME_W'(FRAME_LEN / 2 - 1);
    localparam logic [FRAME_W-1:0] SLOT_LAST_4X = FRAME_W'(FRAME_LEN / 4 - 1);
    localparam logic [FRAME_W-1:0] F2_POS       = FRAME_W'(F2_OFS);
    localparam logic [FRAME_W-1:0] PIT_POS      = FRAME_W'(PIT_OFS);
    localparam logic [PIX_W-1:0]   PIX_LAST     = PIX_W'(PIX_DIV - 1);
    localparam logic [PIX_W-1:0]   PIX_HALF     = PIX_W'(PIX_DIV / 2);
    localparam logic [AUX_W-1:0]   AUX_LAST     = AUX_W'(AUX_DIV - 1);

    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [FRAME_W-1:0] slot_pos_q, slot_pos_d;
    logic [FRAME_W-1:0] slot_last;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [AUX_W-1:0]   aux_cnt_q, aux_cnt_d;
    logic [1:0]         speed_act_q, speed_act_d;
    logic [1:0]         speed_norm;
    logic               paused_q;
    logic               frame_end;

    logic ce_f1_q, ce_f1_d;
    logic ce_f2_q, ce_f2_d;
    logic ce_pit_q, ce_pit_d;
    logic ce_pix_q, ce_pix_d;
    logic ce_pix2x_q, ce_pix2x_d;
    logic ce_aux_q, ce_aux_d;

    assign frame_end  = (frame_cnt_q == FRAME_LAST);
    assign speed_norm = (speed == 2'd3) ? 2'd0 : speed;

    // Slot length is FRAME_LEN >> speed_act; only the wrap point is needed.
    always_comb begin
        unique case (speed_act_q)
            2'd1:    slot_last = SLOT_LAST_2X;
            2'd2:    slot_last = SLOT_LAST_4X;
            default: slot_last = FRAME_LAST;
        endcase
    end

    always_comb begin
        frame_cnt_d = frame_end ? '0 : frame_cnt_q + 1'b1;
        // Forcing the slot counter to 0 at frame end keeps slots aligned across speed changes.
        slot_pos_d  = (frame_end || (slot_pos_q == slot_last)) ? '0 : slot_pos_q + 1'b1;
        pix_cnt_d   = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + 1'b1;
        aux_cnt_d   = (aux_cnt_q == AUX_LAST) ? '0 : aux_cnt_q + 1'b1;
        speed_act_d = frame_end ? speed_norm : speed_act_q;
    end

    always_comb begin
        ce_f1_d    = (slot_pos_q == '0) && !paused_q;
        ce_f2_d    = (slot_pos_q == F2_POS) && !paused_q;
        ce_pit_d   = (frame_cnt_q == PIT_POS);
        ce_pix_d   = (pix_cnt_q == '0);
        ce_pix2x_d = (pix_cnt_q == '0) || (pix_cnt_q == PIX_HALF);
        ce_aux_d   = (aux_cnt_q == '0);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            frame_cnt_q <= '0;
            slot_pos_q  <= '0;
            pix_cnt_q   <= '0;
            aux_cnt_q   <= '0;
            speed_act_q <= 2'd0;
            ce_f1_q     <= 1'b0;
            ce_f2_q     <= 1'b0;
            ce_pit_q    <= 1'b0;
            ce_pix_q    <= 1'b0;
            ce_pix2x_q  <= 1'b0;
            ce_aux_q    <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            slot_pos_q  <= slot_pos_d;
            pix_cnt_q   <= pix_cnt_d;
            aux_cnt_q   <= aux_cnt_d;
            speed_act_q <= speed_act_d;
            ce_f1_q     <= ce_f1_d;
            ce_f2_q     <= ce_f2_d;
            ce_pit_q    <= ce_pit_d;
            ce_pix_q    <= ce_pix_d;
            ce_pix2x_q  <= ce_pix2x_d;
            ce_aux_q    <= ce_aux_d;
        end
    end

`ifdef CLK_STROBE_GEN_PAUSE_EN
    logic paused_d;

    assign paused_d = frame_end ? pause : paused_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            paused_q <= 1'b0;
        end else begin
            paused_q <= paused_d;
        end
    end
`else
    logic unused_pause;

    assign paused_q     = 1'b0;
    assign unused_pause = pause;
`endif

    assign ce_f1     = ce_f1_q;
    assign ce_f2     = ce_f2_q;
    assign ce_pit    = ce_pit_q;
    assign ce_dma    = ce_pit_q;
    assign ce_pix    = ce_pix_q;
    assign ce_pix2x  = ce_pix2x_q;
    assign ce_aux    = ce_aux_q;
    assign speed_act = speed_act_q;
    assign paused    = paused_q;

endmodule

// File: tb/tb_clk_strobe_gen.sv
// Self-checking bench for clk_strobe_gen: cycle-position reference model plus directed strobe-time lists.
// Pause expectations follow CLK_STROBE_GEN_PAUSE_EN when the bench is built with it.
module tb_clk_strobe_gen;

    localparam int FRAME_LEN = 28;
    localparam int F2_OFS    = 2;
    localparam int PIT_OFS   = 4;
    localparam int PIX_DIV   = 6;
    localparam int AUX_W     = 12;
    localparam int AUX_DIV   = 3571;
`ifdef CLK_STROBE_GEN_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [1:0] speed;
    logic       pause;
    logic       ce_f1, ce_f2, ce_pit, ce_dma, ce_pix, ce_pix2x, ce_aux;
    logic [1:0] speed_act;
    logic       paused;

    clk_strobe_gen #(
        .FRAME_LEN(FRAME_LEN),
        .F2_OFS   (F2_OFS),
        .PIT_OFS  (PIT_OFS),
        .PIX_DIV  (PIX_DIV),
        .AUX_W    (AUX_W),
        .AUX_DIV  (AUX_DIV)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .speed    (speed),
        .pause    (pause),
        .ce_f1    (ce_f1),
        .ce_f2    (ce_f2),
        .ce_pit   (ce_pit),
        .ce_dma   (ce_dma),
        .ce_pix   (ce_pix),
        .ce_pix2x (ce_pix2x),
        .ce_aux   (ce_aux),
        .speed_act(speed_act),
        .paused   (paused)
    );

    always #5 clk_sys = ~clk_sys;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference state: t is the observed cycle index since reset release.
    int unsigned t = 0;
    int          m_spd = 0;
    bit          m_pause = 1'b0;
    bit e_f1, e_f2, e_pit, e_pix, e_pix2x, e_aux;

    int f1_hits[$];
    int f2_hits[$];
    int pit_hits[$];
    int aux_hits[$];
    int want[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_miss++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, t, obs, exp_v);
        end
    endtask

    task automatic chk_hits(input string tag, input int got[$], input int exp_q[$]);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            chk({tag, "_time"}, got[i], exp_q[i]);
        end
    endtask

    task automatic clear_hits();
        f1_hits.delete();
        f2_hits.delete();
        pit_hits.delete();
        aux_hits.delete();
    endtask

    // One clock: drive inputs, advance the model across the edge, check all outputs.
    task automatic step(input logic [1:0] spd_in, input logic pause_in, input logic rst_in);
        int unsigned ofs;
        int unsigned slot;
        reset = rst_in;
        speed = spd_in;
        pause = pause_in;
        @(posedge clk_sys);
        if (rst_in) begin
            {e_f1, e_f2, e_pit, e_pix, e_pix2x, e_aux} = '0;
            t       = 0;
            m_spd   = 0;
            m_pause = 1'b0;
        end else begin
            ofs     = t % FRAME_LEN;
            slot    = FRAME_LEN >> m_spd;
            e_f1    = ((ofs % slot) == 0) && !m_pause;
            e_f2    = ((ofs % slot) == F2_OFS) && !m_pause;
            e_pit   = (ofs == PIT_OFS);
            e_pix   = (t % PIX_DIV) == 0;
            e_pix2x = (t % (PIX_DIV / 2)) == 0;
            e_aux   = (t % AUX_DIV) == 0;
            if (ofs == FRAME_LEN - 1) begin
                m_spd   = (spd_in == 2'd3) ? 0 : int'(spd_in);
                m_pause = PAUSE_EN && pause_in;
            end
            t++;
        end
        @(negedge clk_sys);
        chk("ce_f1", ce_f1, e_f1);
        chk("ce_f2", ce_f2, e_f2);
        chk("ce_pit", ce_pit, e_pit);
        chk("ce_dma", ce_dma, e_pit);
        chk("ce_pix", ce_pix, e_pix);
        chk("ce_pix2x", ce_pix2x, e_pix2x);
        chk("ce_aux", ce_aux, e_aux);
        chk("speed_act", speed_act, m_spd);
        chk("paused", paused, m_pause);
        if (ce_f1 === 1'b1)  f1_hits.push_back(t);
        if (ce_f2 === 1'b1)  f2_hits.push_back(t);
        if (ce_pit === 1'b1) pit_hits.push_back(t);
        if (ce_aux === 1'b1) aux_hits.push_back(t);
    endtask

    initial begin
        logic [1:0] r_spd;
        logic       r_pause;
        logic       r_rst;

        reset = 1'b1;
        speed = 2'd0;
        pause = 1'b0;
        @(negedge clk_sys);

        // Reset release at 1x.
        for (int i = 0; i < 3; i++) step(2'd0, 1'b0, 1'b1);
        clear_hits();
        while (t < 60) step(2'd0, 1'b0, 1'b0);
        want = '{1, 29, 57};     chk_hits("s1_f1", f1_hits, want);
        want = '{3, 31, 59};     chk_hits("s1_f2", f2_hits, want);
        want = '{5, 33};         chk_hits("s1_pit", pit_hits, want);
        $display("scenario reset_1x: cycles=%0d vectors=%0d", t, n_vec);

        // Speed 1x -> 2x requested mid-frame.
        step(2'd0, 1'b0, 1'b1);
        clear_hits();
        while (t < 60) step((t >= 10) ? 2'd1 : 2'd0, 1'b0, 1'b0);
        want = '{1, 29, 43, 57}; chk_hits("s2_f1", f1_hits, want);
        want = '{3, 31, 45, 59}; chk_hits("s2_f2", f2_hits, want);
        want = '{5, 33};         chk_hits("s2_pit", pit_hits, want);
        $display("scenario speed_2x: cycles=%0d vectors=%0d", t, n_vec);

        // 4x and reserved speed code, checked against the model.
        step(2'd2, 1'b0, 1'b1);
        while (t < 90) step(2'd2, 1'b0, 1'b0);
        step(2'd3, 1'b0, 1'b1);
        clear_hits();
        while (t < 60) step(2'd3, 1'b0, 1'b0);
        want = '{1, 29, 57};     chk_hits("s3_f1", f1_hits, want);
        $display("scenario speed_4x_and_3: cycles=%0d vectors=%0d", t, n_vec);

        // Pause requested at cycle 10, released at cycle 40.
        step(2'd0, 1'b0, 1'b1);
        clear_hits();
        while (t < 60) step(2'd0, (t >= 10) && (t < 40), 1'b0);
        if (PAUSE_EN) want = '{1, 57};
        else          want = '{1, 29, 57};
        chk_hits("s4_f1", f1_hits, want);
        want = '{5, 33};         chk_hits("s4_pit", pit_hits, want);
        $display("scenario pause: cycles=%0d vectors=%0d", t, n_vec);

        // Long free run with random speed/pause changes; aux cadence.
        step(2'd0, 1'b0, 1'b1);
        clear_hits();
        r_spd   = 2'd0;
        r_pause = 1'b0;
        while (t < 7200) begin
            if ($urandom_range(0, 19) == 0) r_spd = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) r_pause = 1'($urandom_range(0, 1));
            step(r_spd, r_pause, 1'b0);
        end
        want = '{1, 3572, 7143}; chk_hits("s5_aux", aux_hits, want);
        $display("scenario free_run: cycles=%0d vectors=%0d", t, n_vec);

        // Reset mid-frame with 2x and pause latched.
        step(2'd1, 1'b1, 1'b1);
        while (t < 40) step(2'd1, 1'b1, 1'b0);
        step(2'd1, 1'b1, 1'b1);
        clear_hits();
        while (t < 60) step(2'd0, 1'b0, 1'b0);
        want = '{1, 29, 57};     chk_hits("s6_f1", f1_hits, want);
        want = '{5, 33};         chk_hits("s6_pit", pit_hits, want);
        $display("scenario reset_mid: cycles=%0d vectors=%0d", t, n_vec);

        // Random inputs with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 19) == 0) r_spd = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) r_pause = 1'($urandom_range(0, 1));
            step(r_spd, r_pause, r_rst);
        end
        $display("scenario random: vectors=%0d", n_vec);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
